// File: rtl/smsdac_seg_enc_if.sv
// rtl/smsdac_seg_enc_if.sv - sample/mode inputs and element-code output of the segment encoder
interface smsdac_seg_enc_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0]   i_x;
   logic               i_en_enc;
   logic               i_en_dith;
   logic               i_signed;
   logic [2*WIDTH-1:0] o_y;

   modport master (
      output i_x,
      output i_en_enc,
      output i_en_dith,
      output i_signed,
      input  o_y
   );

   modport slave (
      input  i_x,
      input  i_en_enc,
      input  i_en_dith,
      input  i_signed,
      output o_y
   );
endinterface

// File: rtl/smsdac_seg_enc.sv
// rtl/smsdac_seg_enc.sv - mismatch-shaping binary-tree encoder into WIDTH 3-level DAC elements
// Odd residues pick +1/-1 from a per-level toggle (optionally dithered by an LFSR).
module smsdac_seg_enc #(
   parameter int WIDTH = 8
) (
   input  logic           i_clk,
   input  logic           i_rst_b,
   smsdac_seg_enc_if.slave bus
);
   localparam logic [15:0]         LFSR_SEED = 16'hACE1;
   localparam logic signed [WIDTH:0] ONE     = 1;

   logic [WIDTH-1:0]   x_q;
   logic               en_enc_q;
   logic               en_dith_q;
   logic               signed_q;
   logic [WIDTH-2:0]   tog_q;
   logic [15:0]        lfsr_q;
   logic [2*WIDTH-1:0] y_q;

   logic signed [WIDTH:0] s;
   logic signed [WIDTH:0] v;
   logic [WIDTH-2:0]      odd;
   logic [2*WIDTH-1:0]    y_nxt;
   logic                  neg;
   logic                  lfsr_fb;

   assign bus.o_y = y_q;
   assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   always_comb begin
      // Offset binary becomes two's complement by inverting the MSB.
      s     = {{2{x_q[WIDTH-1] ^ ~signed_q}}, x_q[WIDTH-2:0]};
      v     = s;
      odd   = '0;
      y_nxt = '0;
      neg   = 1'b0;
      for (int k = 0; k < WIDTH-1; k++) begin
         if (v[0]) begin
            odd[k]         = 1'b1;
            neg            = tog_q[k] ^ (en_dith_q & lfsr_q[k]);
            y_nxt[2*k+1]   = ~neg;
            y_nxt[2*k]     = neg;
            v              = neg ? ((v + ONE) >>> 1) : ((v - ONE) >>> 1);
         end else begin
            v = v >>> 1;
         end
      end
      // Residue here is always -1, 0 or +1.
      y_nxt[2*WIDTH-1] = ~v[WIDTH] & v[0];
      y_nxt[2*WIDTH-2] = v[WIDTH];
   end

   always_ff @(posedge i_clk or negedge i_rst_b) begin
      if (!i_rst_b) begin
         x_q       <= '0;
         en_enc_q  <= 1'b0;
         en_dith_q <= 1'b0;
         signed_q  <= 1'b0;
         tog_q     <= '0;
         lfsr_q    <= LFSR_SEED;
         y_q       <= '0;
      end else begin
         x_q       <= bus.i_x;
         en_enc_q  <= bus.i_en_enc;
         en_dith_q <= bus.i_en_dith;
         signed_q  <= bus.i_signed;
         tog_q     <= tog_q ^ (odd & {(WIDTH-1){en_enc_q}});
         lfsr_q    <= {lfsr_fb, lfsr_q[15:1]};
         y_q       <= y_nxt;
      end
   end
endmodule

// File: tb/tb_smsdac_seg_enc.sv
// tb/tb_smsdac_seg_enc.sv - scoreboard bench for smsdac_seg_enc at WIDTH=8
module tb_smsdac_seg_enc;
   logic clk = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   smsdac_seg_enc_if #(.WIDTH(8)) bus ();
   smsdac_seg_enc #(.WIDTH(8)) dut (.i_clk(clk), .i_rst_b(rst_b), .bus(bus));

   typedef struct {
      logic [15:0] y;
      int          s;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] m_lfsr;
   logic [6:0]  m_tog;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic lfsr_adv();
      logic fb;
      fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = {fb, m_lfsr[15:1]};
   endtask

   task automatic model(input logic [7:0] x, input logic en, input logic dith, input logic sgn,
                        output logic [15:0] y, output int s);
      int   v;
      int   c;
      logic n;
      lfsr_adv();
      s = sgn ? int'($signed(x)) : int'(x) - 128;
      v = s;
      y = '0;
      for (int k = 0; k < 7; k++) begin
         c = 0;
         if (v % 2 != 0) begin
            n = m_tog[k] ^ (dith & m_lfsr[k]);
            c = n ? -1 : 1;
            y[2*k +: 2] = n ? 2'b01 : 2'b10;
            if (en) m_tog[k] = ~m_tog[k];
         end
         v = (v - c) / 2;
      end
      if (v == 1) y[15:14] = 2'b10;
      else if (v == -1) y[15:14] = 2'b01;
   endtask

   task automatic compare_front();
      exp_t        e;
      int          sum;
      logic        bad;
      logic [1:0]  code;
      e   = sb.pop_front();
      sum = 0;
      bad = 1'b0;
      check({e.tag, "_y"}, 32'(bus.o_y), 32'(e.y));
      for (int k = 0; k < 8; k++) begin
         code = bus.o_y[2*k +: 2];
         if (code == 2'b11) bad = 1'b1;
         else if (code == 2'b10) sum += (1 << k);
         else if (code == 2'b01) sum -= (1 << k);
      end
      check({e.tag, "_sum"}, 32'(sum), 32'(e.s));
      check({e.tag, "_no11"}, 32'(bad), 32'(0));
   endtask

   task automatic step(input logic [7:0] x, input logic en, input logic dith, input logic sgn,
                       input logic use_exp, input logic [15:0] exp_y, input string tag);
      exp_t        e;
      logic [15:0] my;
      int          ms;
      @(negedge clk);
      if (sb.size() == 2) compare_front();
      bus.i_x       = x;
      bus.i_en_enc  = en;
      bus.i_en_dith = dith;
      bus.i_signed  = sgn;
      model(x, en, dith, sgn, my, ms);
      e.y   = use_exp ? exp_y : my;
      e.s   = ms;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         @(negedge clk);
         compare_front();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_b         = 1'b0;
      bus.i_x       = '0;
      bus.i_en_enc  = 1'b0;
      bus.i_en_dith = 1'b0;
      bus.i_signed  = 1'b0;
      sb.delete();
      m_lfsr = 16'hACE1;
      m_tog  = '0;
      repeat (2) @(negedge clk);
      check("reset_y", 32'(bus.o_y), 32'(0));
      rst_b = 1'b1;
      // The first edge after release registers the idle zero sample and advances the LFSR.
      lfsr_adv();
   endtask

   initial begin
      bus.i_x       = '0;
      bus.i_en_enc  = 1'b0;
      bus.i_en_dith = 1'b0;
      bus.i_signed  = 1'b0;

      do_reset();
      step(8'h81, 1, 0, 0, 1, 16'h0002, "alt0");
      step(8'h81, 1, 0, 0, 1, 16'h0009, "alt1");
      step(8'h81, 1, 0, 0, 1, 16'h0002, "alt2");
      for (int i = 0; i < 5; i++) step(8'h81, 1, 0, 0, 0, 16'h0, "alt_n");
      drain();

      // Async assert between edges must clear the output at once.
      @(negedge clk);
      check("pre_rst_nonzero", 32'(bus.o_y != 16'h0), 32'(1));
      #2 rst_b = 1'b0;
      #1 check("async_rst_y", 32'(bus.o_y), 32'(0));

      do_reset();
      for (int i = 0; i < 4; i++) step(8'h81, 0, 0, 0, 1, 16'h0002, "frozen0");
      step(8'h81, 1, 0, 0, 1, 16'h0002, "arm_t0");
      for (int i = 0; i < 4; i++) step(8'h81, 0, 0, 0, 1, 16'h0009, "frozen1");
      drain();

      do_reset();
      for (int i = 0; i < 3; i++) step(8'h00, 1, 0, 0, 1, 16'h4000, "fs_neg");
      drain();
      do_reset();
      step(8'hFF, 1, 0, 0, 1, 16'h2AAA, "fs_pos");
      step(8'hFF, 1, 0, 0, 0, 16'h0, "fs_pos_n");
      drain();

      do_reset();
      step(8'h80, 1, 0, 1, 1, 16'h4000, "sgn_min");
      step(8'h00, 1, 0, 1, 1, 16'h0000, "sgn_zero");
      step(8'h80, 0, 0, 1, 1, 16'h4000, "sgn_min2");
      drain();

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] rx;
         logic       ren, rdi, rsg;
         rx  = 8'($urandom_range(0, 255));
         ren = ($urandom_range(0, 3) != 0);
         rdi = ($urandom_range(0, 7) != 0);
         rsg = 1'($urandom_range(0, 1));
         step(rx, ren, rdi, rsg, 0, 16'h0, "rand");
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
